// File: rtl/local_bus_master.sv
// Local bus master: turns single-word request/response transactions into
// nADS/nCS/nRD strobed bus accesses. Optional DATA-phase timeout: LOCAL_BUS_MASTER_TIMEOUT_EN.
module local_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned RD_SAMPLE_DELAY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [1:0]  req_space_i,
    input  logic [5:0]  req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        nADS_o,
    output logic        WnR_o,
    output logic [5:0]  LA_o,
    inout  wire  [31:0] LD,
    output logic        nCS2_o,
    output logic        nCS3_o,
    output logic        nRD_o,
    input  logic        nREADY_i
);

    localparam int unsigned DAT_W  = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DLY_W  = 4;

    if (RD_SAMPLE_DELAY > 15) begin : g_dly_range
        $error("RD_SAMPLE_DELAY must be in 0..15");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {IDLE, ADDR, DATA, SAMPLE, DONE} state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic                ld_oe, ld_oe_d;
    logic [DAT_W-1:0]    ld_out, ld_out_d;
    logic                ready_d, valid_d, nads_d, wnr_d, ncs2_d, ncs3_d, nrd_d;
    logic [ADDR_W-1:0]   la_d;
    logic [DAT_W-1:0]    rsp_dat_d;

`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rsp_err_d;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Tristate driver straight from the output-enable and data flops
    assign LD = ld_oe ? ld_out : {DAT_W{1'bz}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            dly_q       <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            nADS_o      <= 1'b1;
            WnR_o       <= 1'b0;
            LA_o        <= '0;
            nCS2_o      <= 1'b1;
            nCS3_o      <= 1'b1;
            nRD_o       <= 1'b1;
            ld_oe       <= 1'b0;
            ld_out      <= '0;
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_o   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            dly_q       <= dly_d;
            req_ready_o <= ready_d;
            rsp_valid_o <= valid_d;
            rsp_dat_o   <= rsp_dat_d;
            nADS_o      <= nads_d;
            WnR_o       <= wnr_d;
            LA_o        <= la_d;
            nCS2_o      <= ncs2_d;
            nCS3_o      <= ncs3_d;
            nRD_o       <= nrd_d;
            ld_oe       <= ld_oe_d;
            ld_out      <= ld_out_d;
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
            rsp_err_o   <= rsp_err_d;
`endif
        end
    end

    // Next state plus next value of every registered bus/response output
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        dly_d     = dly_q;
        valid_d   = 1'b0;
        rsp_dat_d = rsp_dat_o;
        nads_d    = 1'b1;
        wnr_d     = WnR_o;
        la_d      = LA_o;
        ncs2_d    = nCS2_o;
        ncs3_d    = nCS3_o;
        nrd_d     = nRD_o;
        ld_oe_d   = ld_oe;
        ld_out_d  = ld_out;
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
        tmo_d     = tmo_q;
        rsp_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d  = ADDR;
                    wr_d     = req_wr_i;
                    nads_d   = 1'b0;
                    wnr_d    = req_wr_i;
                    la_d     = req_addr_i;
                    ncs2_d   = ~req_space_i[0];
                    ncs3_d   = (req_space_i != 2'd2);
                    nrd_d    = 1'b1;
                    ld_oe_d  = req_wr_i;
                    ld_out_d = req_dat_i;
                end
            end
            ADDR: begin
                state_d = DATA;
                nrd_d   = wr_q;
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            DATA: begin
                if (!nREADY_i) begin
                    if (wr_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = SAMPLE;
                        dly_d   = DLY_W'(RD_SAMPLE_DELAY);
                    end
                end
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = '1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            SAMPLE: begin
                if (dly_q == '0) begin
                    rsp_dat_d = LD;
                    state_d   = DONE;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering DONE releases every strobe and the data bus
        if (state_d == DONE) begin
            valid_d = 1'b1;
            ncs2_d  = 1'b1;
            ncs3_d  = 1'b1;
            nrd_d   = 1'b1;
            wnr_d   = 1'b1;
            ld_oe_d = 1'b0;
        end
        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_local_bus_master.sv
// Bench for local_bus_master: timeline-based reference model of each access,
// a responding slave, and a per-cycle compare of every bus and response output.
module tb_local_bus_master;

    localparam int TMO   = 8;
    localparam int DLY   = 2;
    localparam int NEVER = 1 << 30;
`ifdef LOCAL_BUS_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, req_wr_i, nREADY_i;
    logic [1:0]  req_space_i;
    logic [5:0]  req_addr_i;
    logic [31:0] req_dat_i;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        nADS_o, WnR_o, nCS2_o, nCS3_o, nRD_o;
    logic [5:0]  LA_o;
    wire  [31:0] LD;
    logic        tb_oe;
    logic [31:0] tb_ld;

    assign LD = tb_oe ? tb_ld : {32{1'bz}};
    always #5 clk_i = ~clk_i;

    local_bus_master #(.TIMEOUT_CYCLES(TMO), .RD_SAMPLE_DELAY(DLY)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .req_wr_i(req_wr_i), .req_space_i(req_space_i), .req_addr_i(req_addr_i),
        .req_dat_i(req_dat_i), .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .nADS_o(nADS_o), .WnR_o(WnR_o), .LA_o(LA_o), .LD(LD),
        .nCS2_o(nCS2_o), .nCS3_o(nCS3_o), .nRD_o(nRD_o), .nREADY_i(nREADY_i)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: one access as a timeline relative to its acceptance edge.
    // k=0 address phase, k=1..lat data phase, then sample cycles, then done.
    bit          started = 1'b0, rst_seen = 1'b0, active = 1'b0;
    int          t0 = 0, acc_count = 0;
    bit          m_wr, m_tmo;
    logic [1:0]  m_sp;
    logic [5:0]  m_addr;
    logic [31:0] m_data, m_rdata;
    int          m_lat, m_done;
    logic [31:0] exp_rsp = '0;
    int          nxt_lat = 1;
    logic [31:0] nxt_rdata = '0;

    // Observed responses
    int          valid_cnt = 0, last_valid_k = -1, nads_low = 0;
    logic [31:0] last_rsp = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    always @(posedge clk_i) begin
        cyc++;
        started = 1'b1;
        if (rst_i) begin
            active   = 1'b0;
            rst_seen = 1'b1;
            exp_rsp  = '0;
        end else begin
            rst_seen = 1'b0;
            if (active) begin
                if (cyc - 1 - t0 == m_done) begin
                    active = 1'b0;
                    if (m_tmo) exp_rsp = '1;
                    else if (!m_wr) exp_rsp = m_rdata;
                end
            end else if (req_i) begin
                active  = 1'b1;
                t0      = cyc;
                m_wr    = req_wr_i;
                m_sp    = req_space_i;
                m_addr  = req_addr_i;
                m_data  = req_dat_i;
                m_lat   = nxt_lat;
                m_rdata = nxt_rdata;
                m_tmo   = (m_lat == 0) || (TMO_EN && (m_lat > TMO));
                if (m_tmo) m_done = TMO_EN ? TMO + 1 : NEVER;
                else       m_done = m_wr ? m_lat + 1 : m_lat + 2 + DLY;
                acc_count++;
            end
        end
    end

    // Compare process: every output against the model on every cycle
    always @(negedge clk_i) begin : cmp
        int k;
        bit in_acc;
        logic [31:0] want;
        if (started) begin
            if (!nADS_o) nads_low++;
            if (rsp_valid_o) begin
                valid_cnt++;
                last_valid_k = cyc - t0;
                last_rsp     = rsp_dat_o;
                last_err     = rsp_err_o;
            end
            if (rst_seen) begin
                chk1("rst_nADS", nADS_o, 1'b1);
                chk1("rst_nCS2", nCS2_o, 1'b1);
                chk1("rst_nCS3", nCS3_o, 1'b1);
                chk1("rst_nRD", nRD_o, 1'b1);
                chk1("rst_WnR", WnR_o, 1'b0);
                chk("rst_LA", {26'd0, LA_o}, 32'd0);
                chk1("rst_ld_oe", dut.ld_oe, 1'b0);
                chk1("rst_valid", rsp_valid_o, 1'b0);
                chk1("rst_err", rsp_err_o, 1'b0);
                chk("rst_rsp_dat", rsp_dat_o, 32'd0);
                chk1("rst_ready", req_ready_o, 1'b1);
            end else if (!active) begin
                chk1("idle_nADS", nADS_o, 1'b1);
                chk1("idle_nCS2", nCS2_o, 1'b1);
                chk1("idle_nCS3", nCS3_o, 1'b1);
                chk1("idle_nRD", nRD_o, 1'b1);
                chk1("idle_ld_oe", dut.ld_oe, 1'b0);
                chk1("idle_valid", rsp_valid_o, 1'b0);
                chk1("idle_ready", req_ready_o, 1'b1);
                chk("idle_rsp_dat", rsp_dat_o, exp_rsp);
            end else begin
                k      = cyc - t0;
                in_acc = (k < m_done);
                chk1("nADS", nADS_o, k != 0);
                chk1("nCS2", nCS2_o, !(in_acc && m_sp[0]));
                chk1("nCS3", nCS3_o, !(in_acc && m_sp == 2'd2));
                chk1("nRD", nRD_o, !(!m_wr && k >= 1 && in_acc));
                chk1("WnR", WnR_o, in_acc ? m_wr : 1'b1);
                chk("LA", {26'd0, LA_o}, {26'd0, m_addr});
                chk1("ld_oe", dut.ld_oe, m_wr && in_acc);
                if (m_wr && in_acc) chk("LD_write", LD, m_data);
                chk1("busy_ready", req_ready_o, 1'b0);
                chk1("rsp_valid", rsp_valid_o, k == m_done);
                if (k == m_done) begin
                    want = m_tmo ? 32'hFFFF_FFFF : (m_wr ? exp_rsp : m_rdata);
                    chk1("rsp_err", rsp_err_o, m_tmo);
                end else begin
                    want = exp_rsp;
                end
                chk("rsp_dat", rsp_dat_o, want);
            end
        end
    end

    // Slave: nREADY low in data cycle 'lat', read data valid only on the capture cycle
    always @(negedge clk_i) begin : slave
        int k;
        #1;
        k = cyc - t0;
        if (active && k >= 1 && k < m_done && (m_tmo || k <= m_lat))
            nREADY_i = (!m_tmo && k == m_lat) ? 1'b0 : 1'b1;
        else
            nREADY_i = 1'($urandom_range(0, 1));
        if (active && !m_wr && k >= 1 && k < m_done) begin
            tb_oe = 1'b1;
            tb_ld = (k == m_lat + 1 + DLY) ? m_rdata : (m_rdata ^ ($urandom | 32'h1));
        end else begin
            tb_oe = 1'b0;
        end
    end

    task automatic issue(input bit wr, input logic [1:0] sp, input logic [5:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] rd,
                         input bit keep);
        int c0;
        int n;
        req_wr_i    = wr;
        req_space_i = sp;
        req_addr_i  = a;
        req_dat_i   = d;
        nxt_lat     = lat;
        nxt_rdata   = rd;
        req_i       = 1'b1;
        c0 = acc_count;
        n  = 0;
        while (acc_count == c0 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk1("accept_wait", acc_count != c0, 1'b1);
        if (!keep) req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (active && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk1("idle_wait", active, 1'b0);
    endtask

    initial begin
        int v0;
        int n0;
        bit keep;
        rst_i = 1'b1; req_i = 1'b0; req_wr_i = 1'b0; req_space_i = '0;
        req_addr_i = '0; req_dat_i = '0; nREADY_i = 1'b1; tb_oe = 1'b0; tb_ld = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk1("ready_after_reset", req_ready_o, 1'b1);

        // Register read, space 0, addr 0
        n0 = nads_low;
        issue(1'b0, 2'd0, 6'd0, 32'h0, 2, 32'h5355_5246, 1'b0);
        wait_idle();
        chk("reg_rd_data", last_rsp, 32'h5355_5246);
        chk("reg_rd_done_k", 32'(last_valid_k), 32'd6);
        chk1("reg_rd_err", last_err, 1'b0);
        chk("reg_rd_nads_cycles", 32'(nads_low - n0), 32'd1);

        // HK write, space 1, addr 5
        v0 = valid_cnt;
        issue(1'b1, 2'd1, 6'd5, 32'h0000_ABCD, 3, 32'h0, 1'b0);
        wait_idle();
        chk("hk_wr_done_k", 32'(last_valid_k), 32'd4);
        chk("hk_wr_keeps_rsp", last_rsp, 32'h5355_5246);
        chk("hk_wr_pulses", 32'(valid_cnt - v0), 32'd1);

        // Back-to-back reads with req_i held high
        v0 = valid_cnt;
        issue(1'b0, 2'd2, 6'd7, 32'h0, 1, 32'hA5A5_0001, 1'b1);
        issue(1'b0, 2'd3, 6'd63, 32'h0, 4, 32'h0BAD_F00D, 1'b0);
        wait_idle();
        chk("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
        chk("b2b_last_data", last_rsp, 32'h0BAD_F00D);

        // Slave answering on the last data cycle the timeout still allows
        issue(1'b0, 2'd1, 6'd33, 32'h0, TMO, 32'h1234_5678, 1'b0);
        wait_idle();
        chk("late_rd_data", last_rsp, 32'h1234_5678);
        chk1("late_rd_err", last_err, 1'b0);
        chk("late_rd_done_k", 32'(last_valid_k), 32'(TMO + 2 + DLY));

        // Reset asserted during the sample phase
        issue(1'b0, 2'd2, 6'd9, 32'h0, 2, 32'hCAFE_0001, 1'b0);
        repeat (4) @(negedge clk_i);
        v0 = valid_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk("rst_mid_no_pulse", 32'(valid_cnt - v0), 32'd0);
        issue(1'b0, 2'd0, 6'd12, 32'h0, 3, 32'h0F0F_1E1E, 1'b0);
        wait_idle();
        chk("post_rst_rd_data", last_rsp, 32'h0F0F_1E1E);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            keep = ($urandom_range(0, 3) == 0);
            issue(1'($urandom_range(0, 1)), 2'($urandom), 6'($urandom), $urandom,
                  int'($urandom_range(1, 7)), $urandom, keep);
            if (!keep) begin
                if ($urandom_range(0, 1) == 1) wait_idle();
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
            end
        end
        req_i = 1'b0;
        wait_idle();

        // Slave that never answers
        if (TMO_EN) begin
            issue(1'b0, 2'd2, 6'd17, 32'h0, 0, 32'h0, 1'b0);
            wait_idle();
            chk("tmo_rd_done_k", 32'(last_valid_k), 32'(TMO + 1));
            chk1("tmo_rd_err", last_err, 1'b1);
            chk("tmo_rd_data", last_rsp, 32'hFFFF_FFFF);
            issue(1'b1, 2'd1, 6'd3, 32'h1111_2222, 0, 32'h0, 1'b0);
            wait_idle();
            chk1("tmo_wr_err", last_err, 1'b1);
            chk("tmo_wr_done_k", 32'(last_valid_k), 32'(TMO + 1));
        end else begin
            v0 = valid_cnt;
            issue(1'b0, 2'd1, 6'd17, 32'h0, 0, 32'h0, 1'b0);
            repeat (1000) @(negedge clk_i);
            chk("stuck_no_pulse", 32'(valid_cnt - v0), 32'd0);
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
            @(negedge clk_i);
        end
        issue(1'b0, 2'd3, 6'd40, 32'h0, 2, 32'h7E57_0042, 1'b0);
        wait_idle();
        chk("recover_rd_data", last_rsp, 32'h7E57_0042);
        chk1("recover_rd_err", last_err, 1'b0);

        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/local_bus_master.md
LOCAL_BUS_MASTER -- requirements
Module: local_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: DATA-state cycles allowed without nREADY before the access is aborted.
REQ-002 Parameter RD_SAMPLE_DELAY, default 2: cycles from nREADY seen low to the read-data capture edge (range 0-15).
REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1: single clock, all logic posedge.
- rst_i, in, 1: reset, synchronous and active-high.
- req_i, in, 1: access request.
- req_ready_o, out, 1: master idle, request accepted this cycle.
- req_wr_i, in, 1: 1 = write, 0 = read.
- req_space_i, in, 2: 0 = register, 1 = HK (nCS2), 2 = LAB (nCS3), 3 = HK.
- req_addr_i, in, 6: word address, drives LA_o[7:2].
- req_dat_i, in, 32: write data.
- rsp_valid_o, out, 1: one-cycle completion pulse.
- rsp_dat_o, out, 32: read data.
- rsp_err_o, out, 1: timeout flag, qualified by rsp_valid_o.
- nADS_o, out, 1: address strobe, active-low.
- WnR_o, out, 1: 1 = write.
- LA_o, out, 6: local address [7:2].
- LD, inout, 32: local data bus.
- nCS2_o, out, 1: HK chip select.
- nCS3_o, out, 1: LAB chip select.
- nRD_o, out, 1: read strobe.
- nREADY_i, in, 1: slave ready, active-low.

Function
REQ-004 All bus outputs, including the LD output enable, shall come directly from flip-flops clocked on posedge clk_i.
REQ-005 States shall be IDLE, ADDR, DATA, SAMPLE and DONE.
REQ-006 req_ready_o shall be 1 only in IDLE; req_i=1 in IDLE shall latch wr, space, addr and data, then enter ADDR.
REQ-007 ADDR (1 cycle): nADS_o=0; LA_o, WnR_o and the selected nCS shall be valid; LD shall be driven with the latched data when writing; next state DATA.
REQ-008 DATA: nADS_o=1; nCS, LA_o and WnR_o shall be held; nRD_o=0 for reads; LD shall be driven for writes.
REQ-009 DATA exit: nREADY_i sampled low shall go to DONE for a write, or to SAMPLE for a read with the delay counter loaded with RD_SAMPLE_DELAY.
REQ-010 SAMPLE: nRD_o shall stay 0 and the counter shall decrement each cycle; when the counter is 0, LD shall be captured into rsp_dat_o and the state shall go to DONE. RD_SAMPLE_DELAY=0 captures on the first SAMPLE cycle.
REQ-011 DONE (1 cycle): rsp_valid_o=1; nCS2_o, nCS3_o, nRD_o and WnR_o shall return to 1; LD shall be released (Z); next state IDLE.
REQ-012 The master shall leave one bus-idle cycle between accesses: a request is accepted no earlier than the first IDLE cycle after DONE.
REQ-013 Space decode: 0 shall assert neither nCS; 1 and 3 shall assert nCS2_o only; 2 shall assert nCS3_o only.
REQ-014 Write responses shall leave rsp_dat_o unchanged.
REQ-015 rsp_err_o shall be 0 on a normal completion.
REQ-016 nREADY_i low while in IDLE or ADDR shall be ignored.
REQ-017 req_i held high through an access shall be accepted only when back in IDLE.

Reset
REQ-018 rst_i=1 shall set, on the same edge, from any state: IDLE; nADS_o, nCS2_o, nCS3_o and nRD_o = 1; WnR_o = 0; LA_o = 0; LD released; rsp_valid_o, rsp_err_o and rsp_dat_o = 0; counters = 0.
REQ-019 A reset mid-access shall produce no rsp_valid_o pulse.
REQ-020 req_ready_o shall be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-021 Macro LOCAL_BUS_MASTER_TIMEOUT_EN defined: an 8-bit-or-wider counter shall run in DATA. On reaching TIMEOUT_CYCLES without nREADY_i low, the master shall enter DONE with rsp_err_o=1 and rsp_dat_o=32'hFFFFFFFF.
REQ-022 Macro LOCAL_BUS_MASTER_TIMEOUT_EN undefined: no timeout logic; DATA waits indefinitely; rsp_err_o shall be tied 0.

Verification
REQ-023 Register read, space 0, addr 0: slave model returns 0x53555246 with nREADY low 2 cycles after nADS. Required: nADS_o low exactly 1 cycle, nCS2_o=nCS3_o=1, rsp_dat_o=0x53555246, rsp_err_o=0.
REQ-024 HK write, space 1, addr 5, data 0x0000ABCD: nCS2_o=0 from ADDR to DONE, WnR_o=1, LA_o=5, LD=0x0000ABCD through DATA, released in DONE, one rsp_valid_o pulse.
REQ-025 Back-to-back: req_i held high for two reads. Required: at least one idle cycle with nADS_o=1 and all nCS=1 between accesses, two rsp_valid_o pulses.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES=8): nREADY_i stuck high. Required: DONE after 8 DATA cycles, rsp_err_o=1, rsp_dat_o=0xFFFFFFFF. With macro undefined: no rsp_valid_o within 1000 cycles.
REQ-027 rst_i asserted in SAMPLE: next edge all strobes 1, LD Z, no rsp_valid_o; a new read then completes normally.
